// File: rtl/project_select_pkg.sv
// Shared types and register layout for the project select controller.
package project_select_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SWAP   = 2'd2,
    RESUME = 2'd3
  } sel_state_t;

  // Bit positions inside the control/status register
  localparam int SEL_LSB  = 0;
  localparam int SRC_BIT  = 8;
  localparam int BUSY_BIT = 16;
  localparam int ACT_LSB  = 24;
  localparam int ERR_BIT  = 30;
  localparam int DONE_BIT = 31;

endpackage

// File: rtl/cfg_pin_debounce.sv
// Synchroniser plus stability counter for the raw select pins.
module cfg_pin_debounce #(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] stable_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;

  assign synced = sync_q[SYNC_STAGES-1];

  // cnt holds how many cycles synced has matched cand; any change restarts it at 1
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      cand     <= '0;
      cnt      <= '0;
      stable_o <= '0;
    end else begin
      sync_q[0] <= in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      if (synced != cand) begin
        cand <= synced;
        cnt  <= CNT_W'(1);
      end else if (cand != stable_o) begin
        if (cnt >= CNT_W'(DEBOUNCE_CYCLES - 1)) stable_o <= cand;
        else                                     cnt      <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/project_select_ctrl.sv
// Active-project select with sequenced switching: drain, swap, resume.
module project_select_ctrl
  import project_select_pkg::*;
#(
  parameter int          USER_PROJECTS   = 4,
  parameter int          CFG_BITS        = 2,
  parameter logic [31:0] CFG_ADDRESS     = 32'h300FFFFC,
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          QUIET_CYCLES    = 8
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_dat_i,
  input  logic [31:0]              wbs_adr_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  input  logic [CFG_BITS-1:0]      cfg_pins_i,
  output logic [CFG_BITS-1:0]      active_sel_o,
  output logic [USER_PROJECTS-1:0] proj_rst_o,
  output logic                     outputs_quiet_o,
  output logic                     switch_busy_o,
  output logic                     irq_o
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);

  sel_state_t                state, state_nxt;
  logic [QW-1:0]             qcnt, qcnt_nxt;
  logic [CFG_BITS-1:0]       target, target_nxt, active_nxt;
  logic [CFG_BITS-1:0]       sw_sel, pin_sel, req;
  logic                      src, done, err, req_valid, irq_nxt;
  logic [USER_PROJECTS-1:0]  proj_rst_nxt;
  logic                      wb_hit, wb_wr;
  logic [31:0]               reg_rd;
  logic                      unused_bits;

  cfg_pin_debounce #(
    .WIDTH           (CFG_BITS),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .in       (cfg_pins_i),
    .stable_o (pin_sel)
  );

  assign req       = src ? sw_sel : pin_sel;
  assign req_valid = 32'(req) < 32'(USER_PROJECTS);

  // Handshake: a request is stb&cyc at CFG_ADDRESS; ack rises the next cycle for exactly
  // one cycle (masking with ack forces a gap), and read data is valid only while ack is 1.
  assign wb_hit = wbs_stb_i & wbs_cyc_i & (wbs_adr_i == CFG_ADDRESS) & ~wbs_ack_o;
  assign wb_wr  = wb_hit & wbs_we_i;

  assign unused_bits = ^{wbs_dat_i, wbs_sel_i[1]};

  always_comb begin
    reg_rd                       = '0;
    reg_rd[SEL_LSB +: CFG_BITS]  = sw_sel;
    reg_rd[SRC_BIT]              = src;
    reg_rd[BUSY_BIT]             = switch_busy_o;
    reg_rd[ACT_LSB +: CFG_BITS]  = active_sel_o;
    reg_rd[ERR_BIT]              = err;
    reg_rd[DONE_BIT]             = done;
  end

  always_comb begin
    state_nxt  = state;
    qcnt_nxt   = qcnt;
    target_nxt = target;
    active_nxt = active_sel_o;
    irq_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && (req != active_sel_o)) begin
          target_nxt = req;
          qcnt_nxt   = '0;
          state_nxt  = DRAIN;
        end
      end
      DRAIN: begin
        if (qcnt == QW'(QUIET_CYCLES - 1)) begin
          qcnt_nxt  = '0;
          state_nxt = SWAP;
        end else begin
          qcnt_nxt = qcnt + QW'(1);
        end
      end
      SWAP: begin
        active_nxt = target;
        qcnt_nxt   = '0;
        state_nxt  = RESUME;
      end
      RESUME: begin
        if (qcnt == QW'(QUIET_CYCLES - 1)) begin
          irq_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          qcnt_nxt = qcnt + QW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Outputs are derived from the next state so they register in step with it
    if ((state_nxt == DRAIN) || (state_nxt == SWAP)) proj_rst_nxt = '1;
    else proj_rst_nxt = ~(USER_PROJECTS'(1) << active_nxt);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state           <= IDLE;
      qcnt            <= '0;
      target          <= '0;
      active_sel_o    <= '0;
      proj_rst_o      <= '1;
      outputs_quiet_o <= 1'b0;
      switch_busy_o   <= 1'b0;
      irq_o           <= 1'b0;
      sw_sel          <= '0;
      src             <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      wbs_ack_o       <= 1'b0;
      wbs_dat_o       <= '0;
    end else begin
      state           <= state_nxt;
      qcnt            <= qcnt_nxt;
      target          <= target_nxt;
      active_sel_o    <= active_nxt;
      proj_rst_o      <= proj_rst_nxt;
      outputs_quiet_o <= (state_nxt != IDLE);
      switch_busy_o   <= (state_nxt != IDLE);
      irq_o           <= irq_nxt;
      wbs_ack_o       <= wb_hit;
      wbs_dat_o       <= wb_hit ? reg_rd : '0;
      if (wb_wr && wbs_sel_i[0]) sw_sel <= wbs_dat_i[SEL_LSB +: CFG_BITS];
      if (wb_wr && wbs_sel_i[2]) src    <= wbs_dat_i[SRC_BIT];
      // Hardware set beats a same-cycle W1C clear
      if (!req_valid)                                       err <= 1'b1;
      else if (wb_wr && wbs_sel_i[3] && wbs_dat_i[ERR_BIT]) err <= 1'b0;
      if (irq_nxt)                                           done <= 1'b1;
      else if (wb_wr && wbs_sel_i[3] && wbs_dat_i[DONE_BIT]) done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_project_select_ctrl.sv
// Directed bench for project_select_ctrl: a 4-project instance plus a 3-project instance for the error path.
module tb_project_select_ctrl;

  localparam logic [31:0] CFG = 32'h300FFFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stb, stb3, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat, adr;
  logic [1:0]  pins, pins3;

  logic        ack, quiet, busy, irq;
  logic [31:0] rdat;
  logic [1:0]  active;
  logic [3:0]  proj_rst;

  logic        ack3, quiet3, busy3, irq3;
  logic [31:0] rdat3;
  logic [1:0]  active3;
  logic [2:0]  proj_rst3;

  int total = 0;
  int bad = 0;
  int irq_seen = 0;
  int n;

  project_select_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .cfg_pins_i(pins), .active_sel_o(active), .proj_rst_o(proj_rst),
    .outputs_quiet_o(quiet), .switch_busy_o(busy), .irq_o(irq)
  );

  project_select_ctrl #(.USER_PROJECTS(3)) dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb3), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr), .wbs_ack_o(ack3), .wbs_dat_o(rdat3),
    .cfg_pins_i(pins3), .active_sel_o(active3), .proj_rst_o(proj_rst3),
    .outputs_quiet_o(quiet3), .switch_busy_o(busy3), .irq_o(irq3)
  );

  // Counts each irq pulse once, at the edge that ends it
  always @(posedge clk) if (irq === 1'b1) irq_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // Starts on a negedge; returns two negedges later with ack checked high then low
  task automatic wb_access(input logic to3, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           input logic [31:0] exp_rd, input string tag);
    stb = ~to3; stb3 = to3; cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
    @(negedge clk);
    stb = 1'b0; stb3 = 1'b0; cyc = 1'b0; we = 1'b0;
    check({tag, " ack"}, to3 ? ack3 : ack, 32'd1);
    if (!w) check({tag, " rdata"}, to3 ? rdat3 : rdat, exp_rd);
    @(negedge clk);
    check({tag, " ack drop"}, to3 ? ack3 : ack, 32'd0);
  endtask

  task automatic wait_busy(input int limit, output int cnt);
    cnt = 0;
    while (busy !== 1'b1 && cnt < limit) begin @(negedge clk); cnt++; end
  endtask

  task automatic wait_irq(input int limit, output int cnt);
    cnt = 0;
    while (irq !== 1'b1 && cnt < limit) begin @(negedge clk); cnt++; end
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; stb3 = 1'b0; cyc = 1'b0; we = 1'b0;
    sel = 4'h0; dat = '0; adr = '0; pins = 2'b00; pins3 = 2'b00;

    // Reset held for three edges
    @(negedge clk);
    check("rst active_sel", active, 32'd0);
    check("rst proj_rst", proj_rst, 32'hF);
    check("rst quiet", quiet, 32'd0);
    check("rst busy", busy, 32'd0);
    check("rst irq", irq, 32'd0);
    check("rst ack", ack, 32'd0);
    check("rst rdata", rdat, 32'd0);
    step(2);
    rst = 1'b0;
    step(1);
    check("post-rst proj_rst", proj_rst, 32'b1110);
    check("post-rst active_sel", active, 32'd0);
    wb_access(1'b0, 1'b0, CFG, 32'd0, 4'hF, 32'h0000_0000, "reset read");

    // Glitch shorter than the debounce window
    pins = 2'b01;
    step(10);
    pins = 2'b00;
    step(30);
    check("glitch busy", busy, 32'd0);
    check("glitch active_sel", active, 32'd0);
    check("glitch irq count", irq_seen, 32'd0);

    // Pin switch 0 -> 2: 2 sync + 16 stable cycles, then one edge into DRAIN
    pins = 2'b10;
    wait_busy(60, n);
    check("pin switch latency", n, 32'd19);
    for (int i = 0; i < 8; i++) begin
      check("drain quiet", quiet, 32'd1);
      check("drain proj_rst", proj_rst, 32'hF);
      check("drain active_sel", active, 32'd0);
      step(1);
    end
    check("swap quiet", quiet, 32'd1);
    check("swap proj_rst", proj_rst, 32'hF);
    check("swap busy", busy, 32'd1);
    step(1);
    for (int i = 0; i < 8; i++) begin
      check("resume proj_rst", proj_rst, 32'b1011);
      check("resume active_sel", active, 32'd2);
      check("resume quiet", quiet, 32'd1);
      check("resume irq", irq, 32'd0);
      step(1);
    end
    check("done irq", irq, 32'd1);
    check("done quiet", quiet, 32'd0);
    check("done busy", busy, 32'd0);
    step(1);
    check("irq single pulse", irq, 32'd0);
    check("pin irq count", irq_seen, 32'd1);

    // Register access: sw_sel=2 while pins still select, then clear done
    wb_access(1'b0, 1'b1, CFG, 32'h0000_0002, 4'b0001, 32'd0, "wr sw_sel");
    wb_access(1'b0, 1'b0, CFG, 32'd0, 4'hF, 32'h8200_0002, "read after pin switch");
    wb_access(1'b0, 1'b1, CFG, 32'h8000_0000, 4'b1000, 32'd0, "w1c done");
    wb_access(1'b0, 1'b0, CFG, 32'd0, 4'hF, 32'h0200_0002, "read after w1c");

    // Software switch 2 -> 3
    wb_access(1'b0, 1'b1, CFG, 32'h0000_0103, 4'b0101, 32'd0, "wr sw switch");
    check("sw switch busy", busy, 32'd1);
    pins = 2'b00;
    wait_irq(40, n);
    check("sw switch cycles", n + 1, 32'd18);
    check("sw switch active_sel", active, 32'd3);
    step(1);
    wb_access(1'b0, 1'b0, CFG, 32'd0, 4'hF, 32'h8300_0103, "read after sw switch");
    wb_access(1'b0, 1'b1, CFG, 32'h8000_0000, 4'b1000, 32'd0, "w1c done 2");
    wb_access(1'b0, 1'b0, CFG, 32'd0, 4'hF, 32'h0300_0103, "read done cleared");

    // New request during DRAIN of a 3 -> 1 switch
    wb_access(1'b0, 1'b1, CFG, 32'h0000_0001, 4'b0001, 32'd0, "wr sw_sel 1");
    step(2);
    wb_access(1'b0, 1'b1, CFG, 32'h0000_0002, 4'b0001, 32'd0, "wr sw_sel 2 in drain");
    wait_irq(40, n);
    check("first switch active_sel", active, 32'd1);
    check("first switch busy", busy, 32'd0);
    step(1);
    check("second switch started", busy, 32'd1);
    check("second switch proj_rst", proj_rst, 32'hF);
    wait_irq(40, n);
    check("second switch cycles", n + 1, 32'd18);
    check("second switch active_sel", active, 32'd2);
    step(1);
    check("total irq count", irq_seen, 32'd4);

    // Reset asserted mid-RESUME of a 2 -> 1 switch
    wb_access(1'b0, 1'b1, CFG, 32'h0000_0001, 4'b0001, 32'd0, "wr sw_sel 1 again");
    step(10);
    check("mid resume quiet", quiet, 32'd1);
    check("mid resume active_sel", active, 32'd1);
    check("mid resume proj_rst", proj_rst, 32'b1101);
    rst = 1'b1;
    step(1);
    check("mid rst active_sel", active, 32'd0);
    check("mid rst proj_rst", proj_rst, 32'hF);
    check("mid rst quiet", quiet, 32'd0);
    check("mid rst busy", busy, 32'd0);
    check("mid rst irq", irq, 32'd0);
    rst = 1'b0;
    step(1);
    check("after mid rst proj_rst", proj_rst, 32'b1110);
    step(25);
    check("no resumed switch busy", busy, 32'd0);
    check("no resumed switch active", active, 32'd0);
    wb_access(1'b0, 1'b0, CFG, 32'd0, 4'hF, 32'h0000_0000, "read after mid rst");

    // Out-of-range request on the 3-project instance; err set beats W1C clear
    wb_access(1'b1, 1'b1, CFG, 32'h0000_0103, 4'b0101, 32'd0, "dut3 wr sel 3");
    wb_access(1'b1, 1'b0, CFG, 32'd0, 4'hF, 32'h4000_0103, "dut3 read err");
    wb_access(1'b1, 1'b1, CFG, 32'h4000_0000, 4'b1000, 32'd0, "dut3 w1c err");
    wb_access(1'b1, 1'b0, CFG, 32'd0, 4'hF, 32'h4000_0103, "dut3 err still set");
    check("dut3 busy", busy3, 32'd0);
    check("dut3 active_sel", active3, 32'd0);
    check("dut3 proj_rst", proj_rst3, 32'b110);
    check("dut3 quiet", quiet3, 32'd0);
    check("dut3 irq", irq3, 32'd0);

    // Access to a non-matching address
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_0000; sel = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("bad adr ack", ack, 32'd0);
      check("bad adr rdata", rdat, 32'd0);
    end
    stb = 1'b0; cyc = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
